// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

    localparam int BYTE_W  = 8;
    localparam int GRANT_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        ACK,
        DRAIN
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid index at or after ptr, wrapping.
module rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]       valid,
    input  logic [GRANT_W-1:0] ptr,
    output logic [GRANT_W-1:0] idx,
    output logic               any
);

    int best_off;
    int off;

    // Distance from ptr decides priority; the smallest distance among valid inputs wins.
    always_comb begin
        idx      = '0;
        best_off = N;
        off      = 0;
        for (int j = 0; j < N; j++) begin
            off = (j + N - int'(ptr)) % N;
            if (valid[j] && off < best_off) begin
                best_off = off;
                idx      = GRANT_W'(j);
            end
        end
    end

    assign any = |valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter between N_REQ byte streams.
//
// state | meaning
// IDLE  | no grant; pick next requester at or after the pointer
// FETCH | granted; wait for requester byte and idle UART
// START | one-cycle tx_start pulse
// ACK   | wait for tx_busy to rise, or ACK_TIMEOUT cycles
// DRAIN | wait for tx_busy to fall, then release or fetch next byte
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int ACK_TIMEOUT = 16,
    parameter int MAX_PKT     = 64
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [BYTE_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    tx_busy,
    output logic                    tx_start,
    output logic [BYTE_W-1:0]       tx_data,
    output logic [GRANT_W-1:0]      grant_id,
    output logic                    grant_active,
    output logic                    truncated
);

    localparam int CNT_W = (MAX_PKT > 0) ? $clog2(MAX_PKT + 1) : 1;
    localparam int TMR_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

    arb_state_t         state, state_nxt;
    logic [GRANT_W-1:0] ptr;
    logic [GRANT_W-1:0] pick_idx;
    logic               pick_any;
    logic [CNT_W-1:0]   cnt;
    logic [TMR_W-1:0]   timer;
    logic               last_q;
    logic [BYTE_W-1:0]  sel_data;
    logic               sel_valid;
    logic               sel_last;
    logic               accept;
    logic               byte_done;
    logic               release_pkt;
    logic               trunc_pkt;

    rr_pick #(.N(N_REQ)) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_id == GRANT_W'(k)) begin
                sel_data  = req_data[k*BYTE_W +: BYTE_W];
                sel_valid = req_valid[k];
                sel_last  = req_last[k];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        byte_done   = 1'b0;
        release_pkt = 1'b0;
        trunc_pkt   = 1'b0;
        case (state)
            IDLE:  if (pick_any) state_nxt = FETCH;
            FETCH: begin
                if (sel_valid && !tx_busy) begin
                    accept    = 1'b1;
                    state_nxt = START;
                end
            end
            START: state_nxt = ACK;
            ACK: begin
                if (tx_busy)                    state_nxt = DRAIN;
                else if (timer <= TMR_W'(1))    byte_done = 1'b1;
            end
            DRAIN: if (!tx_busy) byte_done = 1'b1;
            default: state_nxt = IDLE;
        endcase
        // A packet ending exactly at the byte limit is a normal release, not a truncation.
        if (byte_done) begin
            if (last_q) begin
                release_pkt = 1'b1;
            end else if (MAX_PKT != 0 && cnt == CNT_W'(MAX_PKT)) begin
                release_pkt = 1'b1;
                trunc_pkt   = 1'b1;
            end
            state_nxt = release_pkt ? IDLE : FETCH;
        end
    end

    always_comb begin
        req_ready = '0;
        for (int k = 0; k < N_REQ; k++) begin
            req_ready[k] = accept && (grant_id == GRANT_W'(k));
        end
    end

    assign tx_start = (state == START);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            ptr          <= '0;
            cnt          <= '0;
            timer        <= '0;
            last_q       <= 1'b0;
            tx_data      <= '0;
            grant_id     <= '0;
            grant_active <= 1'b0;
            truncated    <= 1'b0;
        end else begin
            state     <= state_nxt;
            truncated <= trunc_pkt;
            if (state == IDLE && pick_any) begin
                grant_id     <= pick_idx;
                grant_active <= 1'b1;
            end
            if (accept) begin
                tx_data <= sel_data;
                last_q  <= sel_last;
                cnt     <= cnt + CNT_W'(1);
            end
            if (state == START) begin
                timer <= TMR_W'(ACK_TIMEOUT);
            end else if (state == ACK && timer != '0) begin
                timer <= timer - TMR_W'(1);
            end
            if (release_pkt) begin
                grant_active <= 1'b0;
                cnt          <= '0;
                ptr          <= (grant_id == GRANT_W'(N_REQ - 1)) ? '0 : grant_id + GRANT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-driven requesters, a UART busy model, and a byte log.
module tb_uart_tx_arbiter;

    localparam int N_REQ       = 2;
    localparam int ACK_TIMEOUT = 16;
    localparam int MAX_PKT     = 4;
    localparam int BUSY_LEN    = 10;

    logic                 clk;
    logic                 rstn;
    logic [N_REQ-1:0]     req_valid;
    logic [8*N_REQ-1:0]   req_data;
    logic [N_REQ-1:0]     req_last;
    logic [N_REQ-1:0]     req_ready;
    logic                 tx_busy;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic [2:0]           grant_id;
    logic                 grant_active;
    logic                 truncated;

    uart_tx_arbiter #(
        .N_REQ       (N_REQ),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .MAX_PKT     (MAX_PKT)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_busy      (tx_busy),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .grant_id     (grant_id),
        .grant_active (grant_active),
        .truncated    (truncated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [8:0] rq0[$];
    logic [8:0] rq1[$];
    logic [7:0] byte_log[$];
    logic [2:0] gid_log[$];
    int         cyc_log[$];
    int         ready_cnt[2] = '{0, 0};
    int         trunc_cnt = 0;
    int         hold_err = 0;
    int         ready_bad = 0;
    int         cyc = 0;
    int         busy_left = 0;
    logic       uart_en = 1'b1;
    logic       track = 1'b0;
    logic [7:0] cur_byte = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Requester and UART models: observe at negedge, drive just after posedge.
    initial begin
        tx_busy   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstn) begin
                track = 1'b0;
            end else begin
                if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0) ready_bad++;
                if (req_ready[0] && rq0.size() > 0) begin void'(rq0.pop_front()); ready_cnt[0]++; end
                if (req_ready[1] && rq1.size() > 0) begin void'(rq1.pop_front()); ready_cnt[1]++; end
                if (track && tx_busy && tx_data != cur_byte) hold_err++;
                if (!tx_busy) track = 1'b0;
                if (tx_start) begin
                    byte_log.push_back(tx_data);
                    gid_log.push_back(grant_id);
                    cyc_log.push_back(cyc);
                    cur_byte = tx_data;
                    track    = 1'b1;
                end
                if (truncated) trunc_cnt++;
            end
            if (tx_start && uart_en) busy_left = BUSY_LEN;
            @(posedge clk);
            #1;
            if (busy_left > 0) begin tx_busy = 1'b1; busy_left--; end
            else tx_busy = 1'b0;
            req_valid[0]  = rq0.size() > 0;
            req_data[7:0] = (rq0.size() > 0) ? rq0[0][7:0] : 8'h00;
            req_last[0]   = (rq0.size() > 0) ? rq0[0][8] : 1'b0;
            req_valid[1]  = rq1.size() > 0;
            req_data[15:8]= (rq1.size() > 0) ? rq1[0][7:0] : 8'h00;
            req_last[1]   = (rq1.size() > 0) ? rq1[0][8] : 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic l);
        if (k == 0) rq0.push_back({l, d});
        else        rq1.push_back({l, d});
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int i = 0;
        while (byte_log.size() < n && i < budget) begin tick(); i++; end
        chk("wait_bytes", 32'(byte_log.size()), 32'(n));
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while ((grant_active || tx_busy) && i < budget) begin tick(); i++; end
        chk("wait_idle", {31'b0, grant_active}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_start"},  {31'b0, tx_start},     32'd0);
        chk({tag, "_tx_data"},   {24'b0, tx_data},      32'd0);
        chk({tag, "_req_ready"}, {30'b0, req_ready},    32'd0);
        chk({tag, "_grant_id"},  {29'b0, grant_id},     32'd0);
        chk({tag, "_active"},    {31'b0, grant_active}, 32'd0);
        chk({tag, "_truncated"}, {31'b0, truncated},    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    logic [7:0] exp_c[8];
    logic [7:0] exp_s[6];
    logic [7:0] exp_t[7];

    initial begin
        int base;
        int trunc0;
        int i;
        exp_c = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2, 8'hC0, 8'hD0};
        exp_s = '{8'hE0, 8'hF0, 8'hE1, 8'hE2, 8'hE3, 8'hE4};
        exp_t = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h70, 8'h64, 8'h65};

        rstn = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rstn = 1'b1;
        tick();

        // Single byte from requester 0.
        push(0, 8'h07, 1'b1);
        wait_bytes(1, 200);
        wait_idle(200);
        repeat (5) tick();
        chk("single_count", 32'(byte_log.size()), 32'd1);
        chk("single_data",  {24'b0, byte_log[0]}, 32'h07);
        chk("single_gid",   {29'b0, gid_log[0]},  32'd0);
        chk("single_ready0", 32'(ready_cnt[0]), 32'd1);
        chk("single_ready1", 32'(ready_cnt[1]), 32'd0);

        // Pointer now favours requester 1.
        push(0, 8'h11, 1'b1);
        push(1, 8'h22, 1'b1);
        wait_bytes(3, 400);
        wait_idle(200);
        chk("ptr_first",  {24'b0, byte_log[1]}, 32'h22);
        chk("ptr_second", {24'b0, byte_log[2]}, 32'h11);

        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();

        // Contention: two packets each, grants must alternate at packet boundaries.
        base = byte_log.size();
        push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b1); push(0, 8'hC0, 1'b1);
        push(1, 8'hB0, 1'b0); push(1, 8'hB1, 1'b0); push(1, 8'hB2, 1'b1); push(1, 8'hD0, 1'b1);
        wait_bytes(base + 8, 1000);
        wait_idle(200);
        for (i = 0; i < 8; i++) chk($sformatf("cont_byte%0d", i), {24'b0, byte_log[base+i]}, {24'b0, exp_c[i]});
        chk("cont_gid_b0",   {29'b0, gid_log[base+3]}, 32'd1);
        chk("cont_spacing",  32'(cyc_log[base+1] - cyc_log[base]), 32'(BUSY_LEN + 3));

        // Starvation: requester 0 streams single-byte packets, requester 1 posts one.
        base = byte_log.size();
        for (i = 0; i < 5; i++) push(0, 8'hE0 + 8'(i), 1'b1);
        push(1, 8'hF0, 1'b1);
        wait_bytes(base + 6, 1000);
        wait_idle(200);
        for (i = 0; i < 6; i++) chk($sformatf("starve_byte%0d", i), {24'b0, byte_log[base+i]}, {24'b0, exp_s[i]});

        // ACK timeout with a silent UART.
        uart_en = 1'b0;
        base = byte_log.size();
        push(0, 8'h5A, 1'b0);
        push(0, 8'h5B, 1'b1);
        wait_bytes(base + 2, 400);
        wait_idle(200);
        chk("tmo_byte0",   {24'b0, byte_log[base]},   32'h5A);
        chk("tmo_byte1",   {24'b0, byte_log[base+1]}, 32'h5B);
        chk("tmo_spacing", 32'(cyc_log[base+1] - cyc_log[base]), 32'(ACK_TIMEOUT + 2));
        uart_en = 1'b1;

        // Truncation at MAX_PKT bytes; requester 1 gets the line before the remainder.
        trunc0 = trunc_cnt;
        base = byte_log.size();
        for (i = 0; i < 6; i++) push(0, 8'h60 + 8'(i), (i == 5));
        i = 0;
        while (!grant_active && i < 50) begin tick(); i++; end
        push(1, 8'h70, 1'b1);
        wait_bytes(base + 7, 1500);
        wait_idle(200);
        for (i = 0; i < 7; i++) chk($sformatf("trunc_byte%0d", i), {24'b0, byte_log[base+i]}, {24'b0, exp_t[i]});
        chk("trunc_pulses", 32'(trunc_cnt - trunc0), 32'd1);
        chk("trunc_gid_h0", {29'b0, gid_log[base+4]}, 32'd1);

        // Reset while draining byte 2 of a 5-byte packet.
        base = byte_log.size();
        for (i = 0; i < 5; i++) push(0, 8'h80 + 8'(i), (i == 4));
        wait_bytes(base + 2, 400);
        repeat (3) tick();
        chk("pre_rst_busy", {31'b0, tx_busy}, 32'd1);
        rstn = 1'b0;
        rq0.delete();
        #1;
        chk_reset_outputs("midrst");
        tick();
        rstn = 1'b1;
        tick();
        base = byte_log.size();
        push(1, 8'h90, 1'b0);
        push(1, 8'h91, 1'b1);
        wait_bytes(base + 2, 400);
        wait_idle(200);
        chk("rst_byte0", {24'b0, byte_log[base]},   32'h90);
        chk("rst_byte1", {24'b0, byte_log[base+1]}, 32'h91);
        chk("rst_gid",   {29'b0, gid_log[base]},    32'd1);

        chk("hold_stable", 32'(hold_err),  32'd0);
        chk("ready_legal", 32'(ready_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
